// File: rtl/mag_agc_pkg.sv
// Shared definitions for the magnitude-branch AGC: state encoding, gain width
// and saturating 16-bit arithmetic helpers.
package mag_agc_pkg;

  localparam int unsigned GAIN_W = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MEASURE  = 2'd1;
  localparam logic [1:0] ST_WAIT_EOP = 2'd2;
  localparam logic [1:0] ST_APPLY    = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    MEASURE  = ST_MEASURE,
    WAIT_EOP = ST_WAIT_EOP,
    APPLY    = ST_APPLY
  } state_t;

  // a + b, saturating at all-ones
  function automatic logic [GAIN_W-1:0] sat_add(input logic [GAIN_W-1:0] a,
                                                input logic [GAIN_W-1:0] b);
    logic [GAIN_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[GAIN_W] ? {GAIN_W{1'b1}} : s[GAIN_W-1:0];
  endfunction

  // a - b, saturating at zero
  function automatic logic [GAIN_W-1:0] sat_sub(input logic [GAIN_W-1:0] a,
                                                input logic [GAIN_W-1:0] b);
    logic [GAIN_W:0] s;
    s = {1'b0, a} - {1'b0, b};
    return s[GAIN_W] ? {GAIN_W{1'b0}} : s[GAIN_W-1:0];
  endfunction

endpackage

// File: rtl/mag_agc_ctrl_if.sv
// Monitored magnitude AXI stream bundle.
//   mon_tdata  : unsigned magnitude sample
//   mon_tvalid : stream valid
//   mon_tready : stream ready (beat = tvalid & tready)
//   mon_tlast  : end of packet
// master = stream source side, slave = passive observer (the AGC).
interface mag_agc_ctrl_if;
  logic [mag_agc_pkg::GAIN_W-1:0] mon_tdata;
  logic                           mon_tvalid;
  logic                           mon_tready;
  logic                           mon_tlast;

  modport master (output mon_tdata, output mon_tvalid, output mon_tready, output mon_tlast);
  modport slave  (input  mon_tdata, input  mon_tvalid, input  mon_tready, input  mon_tlast);
endinterface

// File: rtl/mag_peak_window.sv
// Windowed peak detector with sample counter.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the window (peak and count to zero)
//   beat       : a sample is accepted this cycle
//   sample     : sample value
//   done_c     : this beat completes the 2^WINDOW_LOG2 window (combinational)
//   peak_c     : running peak including this cycle's beat (combinational)
module mag_peak_window
  import mag_agc_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              beat,
  input  logic [GAIN_W-1:0] sample,
  output logic              done_c,
  output logic [GAIN_W-1:0] peak_c
);

  localparam int unsigned CNT_W = WINDOW_LOG2;

  logic [CNT_W-1:0]  count_q;
  logic [GAIN_W-1:0] peak_q;

  assign done_c = beat && (&count_q);
  assign peak_c = (beat && (sample > peak_q)) ? sample : peak_q;

  // Accumulate; a completed window restarts itself so the next one begins clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      peak_q  <= '0;
    end else if (clear || done_c) begin
      count_q <= '0;
      peak_q  <= '0;
    end else if (beat) begin
      count_q <= count_q + CNT_W'(1);
      peak_q  <= peak_c;
    end
  end

endmodule

// File: rtl/mag_agc_ctrl.sv
// Automatic gain controller for the magnitude branch. Measures window peaks on
// the monitored stream and steps gain toward target_level with hysteresis,
// applying changes only after a packet boundary.
//   ce_clk, ce_rst_n : clock, async active-low reset
//   mon              : monitored stream (slave modport, observation only)
//   agc_en           : 1 = automatic, 0 = manual (gain follows manual_gain)
//   manual_gain      : manual gain / seed on entry to auto
//   target_level, hysteresis, attack_step, decay_step, gain_min, gain_max
//   gain, gain_stb   : gain to multiplier, one-cycle pulse on auto change
//   last_peak        : peak of most recent completed window
//   state_o          : FSM state readback
// Optional: `define MAG_AGC_TIMEOUT_EN adds a WAIT_EOP timeout (TIMEOUT_CYCLES)
//           and the sticky timeout_flag output.
module mag_agc_ctrl
  import mag_agc_pkg::*;
#(
  parameter int unsigned       WINDOW_LOG2 = 10,
  parameter logic [GAIN_W-1:0] RESET_GAIN  = 16'h1000
`ifdef MAG_AGC_TIMEOUT_EN
  , parameter int unsigned     TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic              ce_clk,
  input  logic              ce_rst_n,
  mag_agc_ctrl_if.slave     mon,
  input  logic              agc_en,
  input  logic [GAIN_W-1:0] manual_gain,
  input  logic [GAIN_W-1:0] target_level,
  input  logic [GAIN_W-1:0] hysteresis,
  input  logic [GAIN_W-1:0] attack_step,
  input  logic [GAIN_W-1:0] decay_step,
  input  logic [GAIN_W-1:0] gain_min,
  input  logic [GAIN_W-1:0] gain_max,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_stb,
  output logic [GAIN_W-1:0] last_peak,
  output logic [1:0]        state_o
`ifdef MAG_AGC_TIMEOUT_EN
  , output logic            timeout_flag
`endif
);

  state_t            state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [GAIN_W-1:0] gain_next_q, gain_next_d;
  logic [GAIN_W-1:0] last_peak_q, last_peak_d;
  logic              stb_q, stb_d;
  logic              mon_beat_c, win_beat_c, win_clear_c, win_done_c;
  logic [GAIN_W-1:0] win_peak_c;

  assign mon_beat_c = mon.mon_tvalid && mon.mon_tready;

  mag_peak_window #(.WINDOW_LOG2(WINDOW_LOG2)) u_win (
    .clk    (ce_clk),
    .rst_n  (ce_rst_n),
    .clear  (win_clear_c),
    .beat   (win_beat_c),
    .sample (mon.mon_tdata),
    .done_c (win_done_c),
    .peak_c (win_peak_c)
  );

  // Next gain from a window peak; an illegal clamp pair (min > max) yields gain_max
  function automatic logic [GAIN_W-1:0] calc_gain(input logic [GAIN_W-1:0] peak,
                                                  input logic [GAIN_W-1:0] cur);
    logic [GAIN_W-1:0] hi, lo, t;
    hi = sat_add(target_level, hysteresis);
    lo = sat_sub(target_level, hysteresis);
    calc_gain = cur;
    if (peak > hi) begin
      t = sat_sub(cur, attack_step);
      calc_gain = (t < gain_min) ? gain_min : t;
      if (gain_min > gain_max) calc_gain = gain_max;
    end else if (peak < lo) begin
      t = sat_add(cur, decay_step);
      calc_gain = (t > gain_max) ? gain_max : t;
      if (gain_min > gain_max) calc_gain = gain_max;
    end
  endfunction

`ifdef MAG_AGC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] timer_q, timer_d;
  logic            tflag_q, tflag_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    gain_next_d = gain_next_q;
    last_peak_d = last_peak_q;
    stb_d       = 1'b0;
    win_beat_c  = 1'b0;
    win_clear_c = 1'b0;
`ifdef MAG_AGC_TIMEOUT_EN
    tflag_d = tflag_q;
    timer_d = (state_q == WAIT_EOP) ? timer_q + TO_W'(1) : '0;
`endif
    if (!agc_en) begin
      state_d     = IDLE;
      gain_d      = manual_gain;
      win_clear_c = 1'b1;
`ifdef MAG_AGC_TIMEOUT_EN
      tflag_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          gain_d      = manual_gain;
          state_d     = MEASURE;
          win_clear_c = 1'b1;
        end
        MEASURE: begin
          win_beat_c = mon_beat_c;
          if (win_done_c) begin
            last_peak_d = win_peak_c;
            gain_next_d = calc_gain(win_peak_c, gain_q);
            state_d     = WAIT_EOP;
          end
        end
        WAIT_EOP: begin
          if (gain_next_q == gain_q) begin
            state_d     = MEASURE;
            win_clear_c = 1'b1;
          end else if (mon_beat_c && mon.mon_tlast) begin
            state_d = APPLY;
            gain_d  = gain_next_q;
            stb_d   = 1'b1;
          end
`ifdef MAG_AGC_TIMEOUT_EN
          else if (timer_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = APPLY;
            gain_d  = gain_next_q;
            stb_d   = 1'b1;
            tflag_d = 1'b1;
          end
`endif
        end
        APPLY: begin
          state_d     = MEASURE;
          win_clear_c = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_q     <= IDLE;
      gain_q      <= RESET_GAIN;
      gain_next_q <= RESET_GAIN;
      last_peak_q <= '0;
      stb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      gain_next_q <= gain_next_d;
      last_peak_q <= last_peak_d;
      stb_q       <= stb_d;
    end
  end

`ifdef MAG_AGC_TIMEOUT_EN
  // WAIT_EOP timer and sticky timeout status
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      timer_q <= '0;
      tflag_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      tflag_q <= tflag_d;
    end
  end
  assign timeout_flag = tflag_q;
`endif

  assign gain      = gain_q;
  assign gain_stb  = stb_q;
  assign last_peak = last_peak_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mag_agc_ctrl.sv
// Directed self-checking bench for mag_agc_ctrl (WINDOW_LOG2 = 4).
module tb_mag_agc_ctrl;
  import mag_agc_pkg::*;

  logic        ce_clk = 1'b0;
  logic        ce_rst_n;
  logic        agc_en;
  logic [15:0] manual_gain, target_level, hysteresis, attack_step, decay_step;
  logic [15:0] gain_min, gain_max;
  logic [15:0] gain, last_peak;
  logic        gain_stb;
  logic [1:0]  state_o;
`ifdef MAG_AGC_TIMEOUT_EN
  logic        timeout_flag;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int stb_cnt  = 0;

  mag_agc_ctrl_if mon_if ();

  mag_agc_ctrl #(
    .WINDOW_LOG2(4)
`ifdef MAG_AGC_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .ce_clk       (ce_clk),
    .ce_rst_n     (ce_rst_n),
    .mon          (mon_if.slave),
    .agc_en       (agc_en),
    .manual_gain  (manual_gain),
    .target_level (target_level),
    .hysteresis   (hysteresis),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .gain_min     (gain_min),
    .gain_max     (gain_max),
    .gain         (gain),
    .gain_stb     (gain_stb),
    .last_peak    (last_peak),
    .state_o      (state_o)
`ifdef MAG_AGC_TIMEOUT_EN
    , .timeout_flag (timeout_flag)
`endif
  );

  always #5 ce_clk = ~ce_clk;

  // Strobe pulses seen, sampled away from the active edge
  always @(negedge ce_clk) if (gain_stb === 1'b1) stb_cnt++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ce_clk);
      #1;
    end
  endtask

  // One accepted beat, then bus idle
  task automatic beat(input logic [15:0] d, input logic last);
    mon_if.mon_tdata  = d;
    mon_if.mon_tlast  = last;
    mon_if.mon_tvalid = 1'b1;
    mon_if.mon_tready = 1'b1;
    step(1);
    mon_if.mon_tvalid = 1'b0;
    mon_if.mon_tlast  = 1'b0;
  endtask

  initial begin
    ce_rst_n = 1'b0;
    agc_en = 1'b0;
    manual_gain = 16'h2000;
    target_level = 16'd1000; hysteresis = 16'd50;
    attack_step = 16'h0100; decay_step = 16'h0100;
    gain_min = 16'h0000; gain_max = 16'hFFFF;
    mon_if.mon_tdata = '0; mon_if.mon_tvalid = 1'b0;
    mon_if.mon_tready = 1'b1; mon_if.mon_tlast = 1'b0;

    // 1: reset values, then manual gain one cycle after release
    #12;
    chk("rst_gain", gain, 16'h1000);
    chk("rst_state", 16'(state_o), 16'd0);
    chk("rst_stb", 16'(gain_stb), 16'd0);
    chk("rst_peak", last_peak, 16'd0);
    @(posedge ce_clk); #1;
    ce_rst_n = 1'b1;
    step(1);
    chk("manual_gain", gain, 16'h2000);
    step(2);
    chk("manual_nostb", 16'(stb_cnt), 16'd0);

    // 2: attack step on peak 2000
    manual_gain = 16'h1000;
    step(1);
    agc_en = 1'b1;
    step(1);
    chk("t2_state_meas", 16'(state_o), 16'd1);
    chk("t2_seed", gain, 16'h1000);
    for (int i = 0; i < 8; i++) beat(16'd2000, 1'b0);
    // valid without ready is not a beat
    mon_if.mon_tdata = 16'hFFFF; mon_if.mon_tvalid = 1'b1; mon_if.mon_tready = 1'b0;
    step(1);
    mon_if.mon_tvalid = 1'b0; mon_if.mon_tready = 1'b1;
    for (int i = 0; i < 7; i++) beat(16'd2000, 1'b0);
    chk("t2_still_meas", 16'(state_o), 16'd1);
    beat(16'd2000, 1'b0);
    chk("t2_state_wait", 16'(state_o), 16'd2);
    chk("t2_last_peak", last_peak, 16'd2000);
    step(3);
    chk("t2_gain_held", gain, 16'h1000);
    beat(16'd7, 1'b1);
    chk("t2_state_apply", 16'(state_o), 16'd3);
    chk("t2_gain_new", gain, 16'h0F00);
    chk("t2_stb_hi", 16'(gain_stb), 16'd1);
    step(1);
    chk("t2_stb_lo", 16'(gain_stb), 16'd0);
    chk("t2_state_meas2", 16'(state_o), 16'd1);
    chk("t2_stb_count", 16'(stb_cnt), 16'd1);

    // 3: decay clamped at gain_max
    gain_max = 16'h1080;
    agc_en = 1'b0;
    step(1);
    chk("t3_manual", gain, 16'h1000);
    chk("t3_idle", 16'(state_o), 16'd0);
    agc_en = 1'b1;
    step(1);
    for (int i = 0; i < 16; i++) beat(16'd500, 1'b0);
    chk("t3_last_peak", last_peak, 16'd500);
    beat(16'd0, 1'b1);
    chk("t3_gain_clamp", gain, 16'h1080);
    step(1);
    chk("t3_stb_count", 16'(stb_cnt), 16'd2);

    // 4: peak inside dead band, no tlast needed, no strobe
    for (int i = 0; i < 16; i++) beat((i == 7) ? 16'd1020 : 16'd100, 1'b0);
    chk("t4_last_peak", last_peak, 16'd1020);
    chk("t4_state_wait", 16'(state_o), 16'd2);
    step(1);
    chk("t4_state_meas", 16'(state_o), 16'd1);
    chk("t4_gain", gain, 16'h1080);
    chk("t4_stb_count", 16'(stb_cnt), 16'd2);

    // 5: tlast on window-completing beat does not apply; the one 40 beats later does
    for (int i = 0; i < 15; i++) beat(16'd3000, 1'b0);
    beat(16'd3000, 1'b1);
    chk("t5_state_wait", 16'(state_o), 16'd2);
    for (int i = 0; i < 39; i++) beat(16'd3000, 1'b0);
    chk("t5_gain_held", gain, 16'h1080);
    chk("t5_still_wait", 16'(state_o), 16'd2);
    beat(16'd3000, 1'b1);
    chk("t5_gain_new", gain, 16'h0F80);
    chk("t5_stb", 16'(gain_stb), 16'd1);
    step(1);
    // new window pending, then drop agc_en in WAIT_EOP
    for (int i = 0; i < 16; i++) beat(16'd3000, 1'b0);
    chk("t5_wait2", 16'(state_o), 16'd2);
    manual_gain = 16'h0555;
    agc_en = 1'b0;
    step(1);
    chk("t5_drop_gain", gain, 16'h0555);
    chk("t5_drop_state", 16'(state_o), 16'd0);
    beat(16'd3000, 1'b1);
    step(1);
    chk("t5_drop_stb", 16'(stb_cnt), 16'd3);
    chk("t5_drop_gain2", gain, 16'h0555);

    // 6: no tlast after a window needing change
    agc_en = 1'b1;
    step(1);
    for (int i = 0; i < 16; i++) beat(16'd3000, 1'b0);
    chk("t6_wait", 16'(state_o), 16'd2);
`ifdef MAG_AGC_TIMEOUT_EN
    step(99);
    chk("t6_pre_to_state", 16'(state_o), 16'd2);
    chk("t6_pre_to_gain", gain, 16'h0555);
    step(1);
    chk("t6_to_state", 16'(state_o), 16'd3);
    chk("t6_to_gain", gain, 16'h0455);
    chk("t6_to_flag", 16'(timeout_flag), 16'd1);
    agc_en = 1'b0;
    step(1);
    chk("t6_flag_clr", 16'(timeout_flag), 16'd0);
`else
    step(200);
    chk("t6_hold_state", 16'(state_o), 16'd2);
    chk("t6_hold_gain", gain, 16'h0555);
    chk("t6_hold_stb", 16'(stb_cnt), 16'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
